// File: rtl/mdu_e_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_e_if
// Brief    : E-stage multiply/divide unit bus (operands, op code, results)
// Revision : 1.0
// ============================================================================
interface mdu_e_if;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_out;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    modport master (
        output md_op, md_a, md_b,
        input  md_busy, md_stall, md_out, hi_q, lo_q
    );

    modport slave (
        input  md_op, md_a, md_b,
        output md_busy, md_stall, md_out, hi_q, lo_q
    );
endinterface
`default_nettype wire

// File: rtl/mdu_e.sv
`default_nettype none
// ============================================================================
// Module   : mdu_e
// Brief    : Multi-cycle mult/div unit with private HI/LO and stall request
// Revision : 1.0
// ============================================================================
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mdu_e_if.slave     bus
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_temp_hi;
    logic [31:0]        r_temp_lo;
    logic               r_commit_en;

    logic               w_is_md;
    logic               w_issue;
    logic               w_done;
    logic               w_busy;
    logic               w_stall;
    logic [31:0]        w_out;

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_div_b;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_commit;

    assign w_is_md = (bus.md_op >= c_OP_MULT) && (bus.md_op <= c_OP_DIVU);
    assign w_issue = (r_state == c_IDLE) && w_is_md;
    assign w_done  = (r_state == c_RUN) && (r_cnt == c_CNT_ONE);

    // Low 64 bits of the sign-extended product equal the signed 32x32 product
    assign w_prod_s = {{32{bus.md_a[31]}}, bus.md_a} * {{32{bus.md_b[31]}}, bus.md_b};
    assign w_prod_u = {32'd0, bus.md_a} * {32'd0, bus.md_b};

    // Divisor forced to 1 on zero so the dividers never see x; the result is discarded anyway
    assign w_div_b = (bus.md_b == 32'd0) ? 32'd1 : bus.md_b;
    assign w_q_s   = $signed(bus.md_a) / $signed(w_div_b);
    assign w_r_s   = $signed(bus.md_a) % $signed(w_div_b);
    assign w_q_u   = bus.md_a / w_div_b;
    assign w_r_u   = bus.md_a % w_div_b;

    always_comb begin
        w_res_hi     = 32'd0;
        w_res_lo     = 32'd0;
        w_res_commit = 1'b1;
        case (bus.md_op)
            c_OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
            c_OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
            c_OP_DIV:   begin
                w_res_hi     = w_r_s;
                w_res_lo     = w_q_s;
                w_res_commit = (bus.md_b != 32'd0);
            end
            c_OP_DIVU:  begin
                w_res_hi     = w_r_u;
                w_res_lo     = w_q_u;
                w_res_commit = (bus.md_b != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_issue) w_state_nxt = c_RUN;
            c_RUN:   if (w_done)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == c_RUN);
        w_stall = w_busy | w_is_md;
        w_out   = 32'd0;
        if (bus.md_op == c_OP_MFHI) w_out = r_hi;
        if (bus.md_op == c_OP_MFLO) w_out = r_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_temp_hi   <= 32'd0;
            r_temp_lo   <= 32'd0;
            r_commit_en <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (w_issue) begin
                r_temp_hi   <= w_res_hi;
                r_temp_lo   <= w_res_lo;
                r_commit_en <= w_res_commit;
                r_cnt       <= (bus.md_op == c_OP_DIV || bus.md_op == c_OP_DIVU) ? c_DIV_CNT : c_MULT_CNT;
            end
            if (bus.md_op == c_OP_MTHI) r_hi <= bus.md_a;
            if (bus.md_op == c_OP_MTLO) r_lo <= bus.md_a;
        end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
            if (w_done && r_commit_en) begin
                r_hi <= r_temp_hi;
                r_lo <= r_temp_lo;
            end
        end
    end

    assign bus.md_busy  = w_busy;
    assign bus.md_stall = w_stall;
    assign bus.md_out   = w_out;
    assign bus.hi_q     = r_hi;
    assign bus.lo_q     = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_e.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_e
// Brief    : Directed self-checking bench for mdu_e
// Revision : 1.0
// ============================================================================
module tb_mdu_e;

    localparam int c_MULT_N = 5;
    localparam int c_DIV_N  = 10;

    logic clk;
    logic reset;
    int   r_tests;
    int   r_fails;

    mdu_e_if bus ();

    mdu_e #(
        .MULT_CYCLES (c_MULT_N),
        .DIV_CYCLES  (c_DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op, then count busy cycles (each must also stall) until busy drops
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp);
        int n_busy;
        bus.md_op = op;
        bus.md_a  = a;
        bus.md_b  = b;
        #1;
        chk({tag, "_issue_stall"}, 32'(bus.md_stall), 32'd1);
        tick();
        bus.md_op = 4'd0;
        n_busy = 0;
        while (bus.md_busy === 1'b1 && n_busy < 50) begin
            n_busy++;
            chk({tag, "_busy_stall"}, 32'(bus.md_stall), 32'd1);
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(n_exp));
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        chk({tag, "_hi_q"}, bus.hi_q, hi_exp);
        chk({tag, "_lo_q"}, bus.lo_q, lo_exp);
        bus.md_op = 4'd5;
        #1;
        chk({tag, "_mfhi"}, bus.md_out, hi_exp);
        bus.md_op = 4'd6;
        #1;
        chk({tag, "_mflo"}, bus.md_out, lo_exp);
        bus.md_op = 4'd0;
        #1;
    endtask

    initial begin
        int n_busy;
        int n_stall;
        r_tests   = 0;
        r_fails   = 0;
        reset     = 1'b0;
        bus.md_op = 4'd0;
        bus.md_a  = 32'd0;
        bus.md_b  = 32'd0;

        #12;
        chk("rst_busy",  32'(bus.md_busy),  32'd0);
        chk("rst_stall", 32'(bus.md_stall), 32'd0);
        chk("rst_hi",    bus.hi_q,          32'd0);
        chk("rst_lo",    bus.lo_q,          32'd0);
        chk("rst_out",   bus.md_out,        32'd0);
        reset = 1'b1;
        tick();

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, c_MULT_N);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002, c_MULT_N);
        read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'h0000_0002, c_DIV_N);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("divu", 4'd4, 32'd100, 32'd7, c_DIV_N);
        read_hilo("divu", 32'd2, 32'd14);

        bus.md_op = 4'd7;
        bus.md_a  = 32'h1234_5678;
        tick();
        bus.md_op = 4'd0;
        chk("mthi_busy", 32'(bus.md_busy), 32'd0);
        read_hilo("mthi", 32'h1234_5678, 32'd14);

        run_op("divu0", 4'd4, 32'd5, 32'd0, c_DIV_N);
        read_hilo("divu0", 32'h1234_5678, 32'd14);

        // mult 0x10000 * 0x10000 = 2^32; illegal ops driven in every busy cycle
        bus.md_op = 4'd1;
        bus.md_a  = 32'h0001_0000;
        bus.md_b  = 32'h0001_0000;
        #1;
        n_stall = (bus.md_stall === 1'b1) ? 1 : 0;
        tick();
        n_busy = 0;
        while (bus.md_busy === 1'b1 && n_busy < 50) begin
            n_busy++;
            if (n_busy == 1) begin
                bus.md_op = 4'd8;
                bus.md_a  = 32'hDEAD_BEEF;
            end else begin
                bus.md_op = 4'd1;
                bus.md_a  = 32'd3;
                bus.md_b  = 32'd3;
            end
            #1;
            if (bus.md_stall === 1'b1) n_stall++;
            tick();
        end
        bus.md_op = 4'd0;
        #1;
        chk("ign_busy_cycles",  32'(n_busy),  32'(c_MULT_N));
        chk("ign_stall_cycles", 32'(n_stall), 32'(c_MULT_N + 1));
        read_hilo("ign", 32'd1, 32'd0);
        tick();
        chk("ign_no_late_issue", 32'(bus.md_busy), 32'd0);

        // Reset mid-divide when the down-counter holds 3
        bus.md_op = 4'd3;
        bus.md_a  = 32'd100;
        bus.md_b  = 32'd7;
        tick();
        bus.md_op = 4'd0;
        repeat (c_DIV_N - 3) tick();
        chk("pre_rst_busy", 32'(bus.md_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.md_busy), 32'd0);
        chk("arst_hi",   bus.hi_q,         32'd0);
        chk("arst_lo",   bus.lo_q,         32'd0);
        #1;
        reset = 1'b1;
        repeat (c_DIV_N + 2) tick();
        chk("post_rst_busy", 32'(bus.md_busy), 32'd0);
        read_hilo("post_rst", 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
